// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// scan state encoding, the all-off segment pattern and the default blank nibble.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_LIT   = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF        = 7'h7F;
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// BCD to seven-segment decoder, active-low, segment A at bit 6 down to G at bit 0.
// Codes 10..15 produce an unlit digit.
module seg_scan_ctrl_decoder
  import seg_pkg::*;
(
  input  logic [3:0] numin,
  output logic [6:0] segout
);

  always_comb begin
    segout = SEG_OFF;
    case (numin)
      4'd0:    segout = 7'b000_0001;
      4'd1:    segout = 7'b100_1111;
      4'd2:    segout = 7'b001_0010;
      4'd3:    segout = 7'b000_0110;
      4'd4:    segout = 7'b100_1100;
      4'd5:    segout = 7'b010_0100;
      4'd6:    segout = 7'b010_0000;
      4'd7:    segout = 7'b000_1111;
      4'd8:    segout = 7'b000_0000;
      4'd9:    segout = 7'b000_0100;
      default: segout = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder, with guard gaps,
// leading-zero blanking and a one-deep word buffer committed only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int         NUM_DIGITS  = 4,
  parameter int         REFRESH_DIV = 100000,
  parameter int         GUARD_CYC   = 16,
  parameter logic [3:0] BLANK_CODE  = BLANK_CODE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lead,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int TICK_W = $clog2(max_int(REFRESH_DIV, GUARD_CYC));
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0] TICK_LIT   = TICK_W'(REFRESH_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_GUARD = TICK_W'(GUARD_CYC - 1);

  scan_state_t                  state_reg, state_next;
  logic [TICK_W-1:0]            tick_reg, tick_next;
  logic [IDX_W-1:0]             idx_reg, idx_next;
  logic                         wrap;

  logic [NUM_DIGITS-1:0][3:0]   active_data_reg, pending_data_reg;
  logic [NUM_DIGITS-1:0]        active_dp_reg, pending_dp_reg;
  logic                         pending_full_reg;
  logic                         accept, commit;

  logic [NUM_DIGITS-1:0]        lead_zero;
  logic                         zero_run;
  logic [3:0]                   digit_nib;
  logic [6:0]                   dec_seg;

  logic [NUM_DIGITS-1:0]        an_reg, an_next;
  logic [6:0]                   seg_reg, seg_next;
  logic                         dp_reg, dp_next;
  logic                         out_hold;
  logic                         frame_done_reg;

  // Scan sequencing: the down-counter reloads on every state change and
  // the state advances once it reaches zero.
  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    idx_next   = idx_reg;
    wrap       = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      tick_next  = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_GUARD;
          tick_next  = TICK_GUARD;
          idx_next   = '0;
        end
        ST_GUARD: begin
          if (tick_reg == '0) begin
            state_next = ST_LIT;
            tick_next  = TICK_LIT;
          end else begin
            tick_next = tick_reg - TICK_W'(1);
          end
        end
        ST_LIT: begin
          if (tick_reg == '0) begin
            state_next = ST_GUARD;
            tick_next  = TICK_GUARD;
            if (idx_reg == IDX_LAST) begin
              idx_next = '0;
              wrap     = 1'b1;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            tick_next = tick_reg - TICK_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          tick_next  = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      idx_reg   <= idx_next;
    end
  end

  // Pending can only be accepted while empty, so an accept never collides with
  // a commit that actually moves data.
  assign load_ready = ~pending_full_reg;
  assign accept     = load_valid & ~pending_full_reg;
  assign commit     = (state_reg == ST_IDLE) | wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_data_reg <= '0;
      pending_dp_reg   <= '0;
      pending_full_reg <= 1'b0;
      active_data_reg  <= '0;
      active_dp_reg    <= '0;
    end else begin
      if (commit && pending_full_reg) begin
        active_data_reg <= pending_data_reg;
        active_dp_reg   <= pending_dp_reg;
      end
      if (accept) begin
        pending_data_reg <= load_data;
        pending_dp_reg   <= load_dp;
        pending_full_reg <= 1'b1;
      end else if (commit && pending_full_reg) begin
        pending_full_reg <= 1'b0;
      end
    end
  end

  // lead_zero[i]: every nibble from the top digit down to i is zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (active_data_reg[i] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    digit_nib = active_data_reg[idx_next];
    if (blank_lead && (idx_next != '0) && lead_zero[idx_next]) begin
      digit_nib = BLANK_CODE;
    end
  end

  seg_scan_ctrl_decoder u_decoder (
    .numin  (digit_nib),
    .segout (dec_seg)
  );

  // Outputs are computed for the state being entered so they line up with it;
  // seg/dp are frozen for the whole lit interval.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (state_next == ST_LIT) begin
      an_next[idx_next] = 1'b0;
      seg_next          = dec_seg;
      dp_next           = ~active_dp_reg[idx_next];
    end
  end

  assign out_hold = (state_reg == ST_LIT) && (state_next == ST_LIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg         <= '1;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      frame_done_reg <= wrap;
      if (!out_hold) begin
        seg_reg <= seg_next;
        dp_reg  <= dp_next;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = frame_done_reg;

endmodule
